// File: rtl/uio_arb_pkg.sv
// Shared types and constants for the uio bus arbiter.
// Optional feature macro: UIO_ARB_SYNC_EN (2-flop synchroniser on uio_in).
package uio_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TURN   = 2'd1,
        DRIVE  = 2'd2,
        SAMPLE = 2'd3
    } uio_arb_state_t;

    localparam int          UIO_ARB_MAX_REQ = 4;
    localparam int          IDX_W           = 2;
    localparam logic        DIR_WRITE       = 1'b1;
    localparam logic        DIR_READ        = 1'b0;
    localparam logic [7:0]  OE_DRIVE        = 8'hFF;
    localparam logic [7:0]  OE_RELEASE      = 8'h00;

endpackage

// File: rtl/uio_rr_arbiter.sv
// Combinational round-robin picker: the search starts one past last_grant
// and wraps, so the most recent winner has the lowest priority.
module uio_rr_arbiter
    import uio_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any
);

    logic [IDX_W-1:0]   pos;
    logic [NUM_REQ-1:0] req_rot;

    // Walk the requesters in priority order and keep the first one asking.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        pos       = '0;
        req_rot   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            pos     = IDX_W'((int'(last_grant) + k) % NUM_REQ);
            req_rot = req >> pos;
            if (!any && req_rot[0]) begin
                any       = 1'b1;
                grant_idx = pos;
            end
        end
        if (any) begin
            grant = NUM_REQ'(1) << grant_idx;
        end
    end

endmodule

// File: rtl/uio_bus_arbiter.sv
// Shares the eight uio pads between up to four requesters, one byte-wide
// transaction at a time, with a turnaround cycle on every direction change.
// Optional feature macro: UIO_ARB_SYNC_EN -- uio_in goes through a 2-flop
// synchroniser and SAMPLE is stretched by two cycles to cover its latency.
// Handshake: req_ready[w] is a combinational one-cycle pulse in IDLE; the
// request is taken when req_valid[w] and req_ready[w] are both high.
// rsp_valid is a registered one-cycle pulse with rsp_rdata alongside.
module uio_bus_arbiter
    import uio_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int HOLD    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_write,
    input  logic [8*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic [7:0]           rsp_rdata,
    input  logic [7:0]           uio_in,
    output logic [7:0]           uio_out,
    output logic [7:0]           uio_oe,
    output logic                 bus_strobe,
    output logic                 bus_dir,
    output logic                 busy
);

`ifdef UIO_ARB_SYNC_EN
    // HOLD+2 can reach 17 cycles, one more than a 4-bit counter can hold.
    localparam int SAMPLE_LEN = HOLD + 2;
    localparam int CNT_W      = 5;
`else
    localparam int SAMPLE_LEN = HOLD;
    localparam int CNT_W      = 4;
`endif
    localparam logic [CNT_W-1:0] DRIVE_LOAD  = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0] SAMPLE_LOAD = CNT_W'(SAMPLE_LEN - 1);

    uio_arb_state_t       state, state_n;
    logic [CNT_W-1:0]     cnt;
    logic                 last_dir;
    logic [IDX_W-1:0]     last_grant, grant_idx;
    logic [NUM_REQ-1:0]   grant, cur_grant, write_rot;
    logic [8*NUM_REQ-1:0] wdata_rot;
    logic                 any, accept, sel_write;
    logic [7:0]           sel_wdata, wdata_q, sample_byte;

    uio_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .any        (any)
    );

    // Pick out the winner's direction and write byte.
    always_comb begin
        write_rot = req_write >> grant_idx;
        sel_write = write_rot[0];
        wdata_rot = req_wdata >> {grant_idx, 3'b000};
        sel_wdata = wdata_rot[7:0];
        accept    = (state == IDLE) && ena && any;
    end

    // Next-state logic; last_dir already holds the new direction in TURN.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (sel_write != last_dir) state_n = TURN;
                    else if (sel_write)        state_n = DRIVE;
                    else                       state_n = SAMPLE;
                end
            end
            TURN:          state_n = (last_dir == DIR_WRITE) ? DRIVE : SAMPLE;
            DRIVE, SAMPLE: if (cnt == '0) state_n = IDLE;
            default:       state_n = IDLE;
        endcase
    end

    // Pad and status outputs decode straight from state so reset clears them at once.
    always_comb begin
        uio_oe     = (state == DRIVE) ? OE_DRIVE : OE_RELEASE;
        uio_out    = (state == DRIVE) ? wdata_q : 8'h00;
        bus_strobe = (state == DRIVE) || (state == SAMPLE);
        busy       = (state != IDLE);
        bus_dir    = last_dir;
        req_ready  = accept ? grant : '0;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Phase counter: loaded on entry to a data phase, counts down to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state_n != state && state_n == DRIVE) begin
            cnt <= DRIVE_LOAD;
        end else if (state_n != state && state_n == SAMPLE) begin
            cnt <= SAMPLE_LOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Capture the accepted transaction and advance the round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_dir   <= DIR_READ;
            last_grant <= IDX_W'(NUM_REQ - 1);
            wdata_q    <= 8'h00;
            cur_grant  <= '0;
        end else if (accept) begin
            last_dir   <= sel_write;
            last_grant <= grant_idx;
            wdata_q    <= sel_wdata;
            cur_grant  <= grant;
        end
    end

`ifdef UIO_ARB_SYNC_EN
    logic [7:0] sync1, sync2;

    // Two-flop synchroniser on the pad input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 8'h00;
            sync2 <= 8'h00;
        end else begin
            sync1 <= uio_in;
            sync2 <= sync1;
        end
    end
    assign sample_byte = sync2;
`else
    assign sample_byte = uio_in;
`endif

    // Register the read byte on the last SAMPLE cycle and pulse the issuer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= '0;
            rsp_rdata <= 8'h00;
        end else if (state == SAMPLE && cnt == '0) begin
            rsp_valid <= cur_grant;
            rsp_rdata <= sample_byte;
        end else begin
            rsp_valid <= '0;
        end
    end

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Bench for uio_bus_arbiter: a transaction-timeline model checked every
// cycle, plus directed scenarios with hand-computed cycle expectations.
module tb_uio_bus_arbiter;

    localparam int NUM_REQ = 2;
    localparam int HOLD    = 2;
`ifdef UIO_ARB_SYNC_EN
    localparam int SLEN = HOLD + 2;
`else
    localparam int SLEN = HOLD;
`endif
    localparam int SW = 20;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 ena;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_write;
    logic [8*NUM_REQ-1:0] req_wdata;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   rsp_valid;
    logic [7:0]           rsp_rdata;
    logic [7:0]           uio_in;
    logic [7:0]           uio_out;
    logic [7:0]           uio_oe;
    logic                 bus_strobe;
    logic                 bus_dir;
    logic                 busy;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    uio_bus_arbiter #(.NUM_REQ(NUM_REQ), .HOLD(HOLD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .uio_in     (uio_in),
        .uio_out    (uio_out),
        .uio_oe     (uio_oe),
        .bus_strobe (bus_strobe),
        .bus_dir    (bus_dir),
        .busy       (busy)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Model: each accepted transaction expands into a timeline of expected
    // per-cycle pad states {oe, out, strobe, last_sample, who}.
    logic [SW-1:0]      exp_q[$];
    logic               m_dir;
    int                 m_last;
    logic [NUM_REQ-1:0] m_rsp;
    logic [7:0]         m_rdata;

    function automatic logic [SW-1:0] mk_slot(input logic [7:0] oe, input logic [7:0] out,
                                              input logic strobe, input logic last, input int who);
        return {oe, out, strobe, last, 2'(who)};
    endfunction

    always @(negedge clk) begin
        logic [SW-1:0]      cur;
        logic [NUM_REQ-1:0] exp_ready;
        logic               acc;
        logic               wr;
        int                 w;
        int                 c;
        if (!rst_n) begin
            exp_q.delete();
            m_dir  = 1'b0;
            m_last = NUM_REQ - 1;
            m_rsp  = '0;
            chk("rst_oe", 32'(uio_oe), 0);
            chk("rst_out", 32'(uio_out), 0);
            chk("rst_strobe", 32'(bus_strobe), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_dir", 32'(bus_dir), 0);
            chk("rst_ready", 32'(req_ready), 0);
            chk("rst_rsp", 32'(rsp_valid), 0);
            chk("rst_rdata", 32'(rsp_rdata), 0);
        end else begin
            cur       = (exp_q.size() != 0) ? exp_q[0] : '0;
            exp_ready = '0;
            acc       = 1'b0;
            w         = 0;
            if (exp_q.size() == 0 && ena) begin
                for (int k = 1; k <= NUM_REQ; k++) begin
                    c = (m_last + k) % NUM_REQ;
                    if (!acc && req_valid[c]) begin
                        acc = 1'b1;
                        w   = c;
                    end
                end
            end
            if (acc) exp_ready[w] = 1'b1;
            chk("m_oe", 32'(uio_oe), 32'(cur[19:12]));
            chk("m_out", 32'(uio_out), 32'(cur[11:4]));
            chk("m_strobe", 32'(bus_strobe), 32'(cur[3]));
            chk("m_busy", 32'(busy), 32'(exp_q.size() != 0));
            chk("m_dir", 32'(bus_dir), 32'(m_dir));
            chk("m_ready", 32'(req_ready), 32'(exp_ready));
            chk("m_rsp", 32'(rsp_valid), 32'(m_rsp));
            if (m_rsp != '0) chk("m_rdata", 32'(rsp_rdata), 32'(m_rdata));
            // advance one cycle
            m_rsp = '0;
            if (exp_q.size() != 0) begin
                cur = exp_q.pop_front();
                if (cur[2]) begin
                    m_rsp[cur[1:0]] = 1'b1;
                    m_rdata = uio_in;
                end
            end
            if (acc) begin
                wr = req_write[w];
                if (wr != m_dir) exp_q.push_back(mk_slot(8'h00, 8'h00, 1'b0, 1'b0, 0));
                if (wr) begin
                    for (int i = 0; i < HOLD; i++)
                        exp_q.push_back(mk_slot(8'hFF, req_wdata[8*w +: 8], 1'b1, 1'b0, 0));
                end else begin
                    for (int i = 0; i < SLEN; i++)
                        exp_q.push_back(mk_slot(8'h00, 8'h00, 1'b1, i == SLEN - 1, w));
                end
                m_dir  = wr;
                m_last = w;
            end
        end
    end

    // Driver helpers.
    task automatic wait_to(input int n);
        @(negedge clk);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic wait_ready(output int idx, output int at);
        int n;
        n   = 0;
        idx = -1;
        at  = -1;
        @(negedge clk);
        while (req_ready == '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (req_ready != '0) begin
            idx = (req_ready == 2'b10) ? 1 : 0;
            at  = cyc;
        end else begin
            chk("ready_timeout", 32'(req_ready), 32'hFFFF_FFFF);
        end
    endtask

    task automatic do_req(input int r, input logic wr, input logic [7:0] d, output int at);
        int idx;
        @(posedge clk); #1;
        req_valid[r]       = 1'b1;
        req_write[r]       = wr;
        req_wdata[8*r +: 8] = d;
        wait_ready(idx, at);
        chk("grant_idx", 32'(idx), 32'(r));
        @(posedge clk); #1;
        req_valid[r] = 1'b0;
    endtask

    // Directed scenarios.
    initial begin
        int at;
        int idx;
        rst_n = 1'b0; ena = 1'b0; req_valid = '0; req_write = '0; req_wdata = '0; uio_in = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_oe", 32'(uio_oe), 0);
        chk("reset_busy", 32'(busy), 0);
        rst_n = 1'b1;
        ena   = 1'b1;

        // Requester 0 write A5: turn first since the bus resets to read.
        do_req(0, 1'b1, 8'hA5, at);
        wait_to(at + 1);
        chk("t1_turn_oe", 32'(uio_oe), 0);
        chk("t1_turn_busy", 32'(busy), 1);
        wait_to(at + 2);
        chk("t1_d1_oe", 32'(uio_oe), 32'hFF);
        chk("t1_d1_out", 32'(uio_out), 32'hA5);
        wait_to(at + 3);
        chk("t1_d2_oe", 32'(uio_oe), 32'hFF);
        chk("t1_d2_out", 32'(uio_out), 32'hA5);
        wait_to(at + 4);
        chk("t1_end_oe", 32'(uio_oe), 0);
        chk("t1_end_busy", 32'(busy), 0);

        // Requester 1 write (no turn) then read of 3C (turn).
        do_req(1, 1'b1, 8'h5E, at);
        wait_to(at + 1);
        chk("t2_w_oe", 32'(uio_oe), 32'hFF);
        chk("t2_w_out", 32'(uio_out), 32'h5E);
        uio_in = 8'h3C;
        do_req(1, 1'b0, 8'h00, at);
        wait_to(at + 1);
        chk("t2_turn_oe", 32'(uio_oe), 0);
        chk("t2_turn_strobe", 32'(bus_strobe), 0);
        wait_to(at + SLEN + 1);
        chk("t2_rsp_early", 32'(rsp_valid), 0);
        wait_to(at + SLEN + 2);
        chk("t2_rsp_valid", 32'(rsp_valid), 32'b10);
        chk("t2_rsp_rdata", 32'(rsp_rdata), 32'h3C);

        // Both requesters hold continuous reads.
        @(posedge clk); #1;
        uio_in = 8'h77; req_write = 2'b00; req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            wait_ready(idx, at);
            chk("t3_rr_order", 32'(idx), 32'(i % 2));
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_to(at + SLEN + 1);
        chk("t3_last_rsp", 32'(rsp_valid), 32'b10);
        chk("t3_last_rdata", 32'(rsp_rdata), 32'h77);

        // ena dropped during DRIVE: transfer completes, no accept until ena returns.
        @(posedge clk); #1;
        req_write = 2'b01; req_wdata[7:0] = 8'hC3; req_valid = 2'b01;
        wait_ready(idx, at);
        chk("t4_first", 32'(idx), 0);
        @(posedge clk); #1;
        req_valid = 2'b10; req_write = 2'b11; req_wdata[15:8] = 8'h4D;
        @(posedge clk); #1;
        ena = 1'b0;
        wait_to(at + 2);
        chk("t4_d1_oe", 32'(uio_oe), 32'hFF);
        wait_to(at + 3);
        chk("t4_d2_oe", 32'(uio_oe), 32'hFF);
        chk("t4_d2_out", 32'(uio_out), 32'hC3);
        wait_to(at + 4);
        chk("t4_idle_busy", 32'(busy), 0);
        for (int i = 0; i < 5; i++) begin
            wait_to(at + 4 + i);
            chk("t4_no_ready", 32'(req_ready), 0);
        end
        @(posedge clk); #1;
        ena = 1'b1;
        wait_ready(idx, at);
        chk("t4_after_ena", 32'(idx), 1);
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_to(at + 1);
        chk("t4_w2_out", 32'(uio_out), 32'h4D);
        wait_to(at + HOLD + 1);
        chk("t4_w2_done", 32'(busy), 0);

        // Reset in the middle of SAMPLE.
        uio_in = 8'h99;
        do_req(0, 1'b0, 8'h00, at);
        wait_to(at + 2);
        chk("t5_sample_strobe", 32'(bus_strobe), 1);
        #2;
        rst_n = 1'b0;
        req_valid = 2'b00;
        #1;
        chk("t5_rst_oe", 32'(uio_oe), 0);
        chk("t5_rst_strobe", 32'(bus_strobe), 0);
        chk("t5_rst_busy", 32'(busy), 0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < SLEN + 3; i++) begin
            @(negedge clk);
            chk("t5_no_rsp", 32'(rsp_valid), 0);
        end

        // After reset requester 0 wins first; read of 5A with no turn.
        @(posedge clk); #1;
        uio_in = 8'h5A; req_write = 2'b00; req_valid = 2'b11;
        wait_ready(idx, at);
        chk("t6_first_grant", 32'(idx), 0);
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_to(at + SLEN);
        chk("t6_rsp_early", 32'(rsp_valid), 0);
        wait_to(at + SLEN + 1);
        chk("t6_rsp_valid", 32'(rsp_valid), 32'b01);
        chk("t6_rsp_rdata", 32'(rsp_rdata), 32'h5A);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
